// File: rtl/stereo_disp_select.sv
// stereo_disp_select: L2R/R2L winner-take-all disparity with runtime
// max disparity, cost ceiling, left-right check and end-of-line flush.
module stereo_disp_select #(
  parameter int D    = 64,
  parameter int WC   = 7,
  parameter int WH   = 13,
  parameter int M    = 450,
  parameter int DBIT = $clog2(D),
  parameter int CBIT = $clog2(((WC**2)/2)*(WH**2)),
  parameter int XBIT = $clog2(M)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dval,
  input  logic              i_eol,
  input  logic [D*CBIT-1:0] i_cost,
  input  logic [DBIT-1:0]   i_dmax,
  input  logic [DBIT-1:0]   i_thresh_lrcc,
  input  logic [CBIT-1:0]   i_cost_max,
  output logic              o_ready,
  output logic              o_dval,
  output logic [DBIT-1:0]   o_data,
  output logic              o_err,
  output logic              o_eol
);

  localparam logic [XBIT-1:0] XLAST = XBIT'(M-1);
  localparam logic [DBIT-1:0] DLAST = DBIT'(D-1);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic [DBIT-1:0] d;
    logic [CBIT-1:0] c;
    logic            eol;
  } px_t;

  state_t state;
  state_t state_nx;

  logic            ready;
  logic            bubble;
  logic            acc;
  logic            step;
  logic            first;
  logic            eval;
  logic [XBIT-1:0] col;
  logic [DBIT-1:0] dm_q;
  logic [DBIT-1:0] dm_in;
  logic [DBIT-1:0] dm_now;
  logic [DBIT-1:0] lead;
  logic [DBIT-1:0] lead_cur;
  logic [DBIT-1:0] fcnt;

  logic [CBIT-1:0] cost [D];
  logic [CBIT-1:0] ch_c [D];
  logic [DBIT-1:0] ch_d [D];
  logic [CBIT-1:0] nx_c [D];
  logic [DBIT-1:0] nx_d [D];
  logic [DBIT-1:0] l_d;
  logic [CBIT-1:0] l_c;

  px_t             dl   [D];
  logic [DBIT-1:0] dr_b [D];

  logic            ev1;
  logic            s2_v;
  logic [DBIT-1:0] s2_d;
  logic [CBIT-1:0] s2_c;
  logic            s2_e;
  logic [DBIT:0]   s2_diff;

  px_t             pick;
  logic [DBIT:0]   ad;
  logic [DBIT:0]   ar;
  logic [DBIT:0]   diff;
  logic            err;

  assign acc   = i_dval & ready;
  assign step  = acc | bubble;
  assign first = acc & (col == '0);

  always_comb begin
    dm_in = i_dmax;
    if (int'(i_dmax) > D-1) dm_in = DLAST;
  end

  assign dm_now   = first ? dm_in : dm_q;
  assign lead_cur = first ? '0 : lead;
  assign eval     = step & (lead_cur == dm_now);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (acc && i_eol && dm_now != '0)
          state_nx = FLUSH;
      end
      FLUSH: begin
        if (fcnt == dm_q - DBIT'(1))
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    bubble = 1'b0;
    unique case (state)
      RUN:     ready  = 1'b1;
      FLUSH:   bubble = 1'b1;
      default: ready  = 1'b1;
    endcase
  end

  assign o_ready = ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || state == RUN) fcnt <= '0;
    else                       fcnt <= fcnt + DBIT'(1);
  end

  // Out-of-range lanes and flush bubbles never win: force them to max cost.
  always_comb begin
    for (int d = 0; d < D; d++) begin
      cost[d] = i_cost[d*CBIT +: CBIT];
      if (bubble || d > int'(dm_now) || d > int'(col))
        cost[d] = '1;
    end
  end

  always_comb begin
    l_c = cost[0];
    l_d = '0;
    for (int d = 1; d < D; d++) begin
      if (cost[d] < l_c) begin
        l_c = cost[d];
        l_d = DBIT'(d);
      end
    end
  end

  // Entry k tracks right pixel x-k; strict compare keeps the smaller d.
  always_comb begin
    nx_c[0] = cost[0];
    nx_d[0] = '0;
    for (int k = 1; k < D; k++) begin
      nx_c[k] = ch_c[k-1];
      nx_d[k] = ch_d[k-1];
      if (cost[k] < ch_c[k-1]) begin
        nx_c[k] = cost[k];
        nx_d[k] = DBIT'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col  <= '0;
      dm_q <= '0;
      lead <= '0;
      for (int k = 0; k < D; k++) begin
        ch_c[k] <= '0;
        ch_d[k] <= '0;
        dl[k]   <= '0;
        dr_b[k] <= '0;
      end
    end else if (step) begin
      for (int k = 0; k < D; k++) begin
        ch_c[k] <= nx_c[k];
        ch_d[k] <= nx_d[k];
      end
      dl[0]   <= '{d: l_d, c: l_c, eol: acc & i_eol};
      dr_b[0] <= nx_d[dm_now];
      for (int k = 1; k < D; k++) begin
        dl[k]   <= dl[k-1];
        dr_b[k] <= dr_b[k-1];
      end
      if (lead_cur == dm_now) lead <= lead_cur;
      else                    lead <= lead_cur + DBIT'(1);
      if (first) dm_q <= dm_in;
      if (acc) begin
        if (i_eol)              col <= '0;
        else if (col == XLAST)  col <= col;
        else                    col <= col + XBIT'(1);
      end
    end
  end

  // Lines are frozen between steps, so the lookup can trail the step.
  always_comb begin
    pick = dl[dm_q];
    ad   = {1'b0, pick.d};
    ar   = {1'b0, dr_b[pick.d]};
    diff = (ad > ar) ? ad - ar : ar - ad;
  end

  assign err = (s2_diff > {1'b0, i_thresh_lrcc}) | (s2_c > i_cost_max);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ev1     <= 1'b0;
      s2_v    <= 1'b0;
      s2_d    <= '0;
      s2_c    <= '0;
      s2_e    <= 1'b0;
      s2_diff <= '0;
      o_dval  <= 1'b0;
      o_data  <= '0;
      o_err   <= 1'b0;
      o_eol   <= 1'b0;
    end else begin
      ev1     <= eval;
      s2_v    <= ev1;
      s2_d    <= pick.d;
      s2_c    <= pick.c;
      s2_e    <= pick.eol;
      s2_diff <= diff;
      o_dval  <= s2_v;
      o_data  <= (s2_v && !err) ? s2_d : '0;
      o_err   <= s2_v & err;
      o_eol   <= s2_v & s2_e;
    end
  end

endmodule

// File: tb/tb_stereo_disp_select.sv
// tb_stereo_disp_select: random and directed lines checked by a
// scoreboard against a line-level disparity reference model.
module tb_stereo_disp_select;

  localparam int D    = 64;
  localparam int DBIT = 6;
  localparam int CBIT = 12;
  localparam int CMAX = 4095;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_dval;
  logic              i_eol;
  logic [D*CBIT-1:0] i_cost;
  logic [DBIT-1:0]   i_dmax;
  logic [DBIT-1:0]   i_thresh;
  logic [CBIT-1:0]   i_cmax;
  logic              o_ready;
  logic              o_dval;
  logic [DBIT-1:0]   o_data;
  logic              o_err;
  logic              o_eol;

  stereo_disp_select dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_dval(i_dval),
    .i_eol(i_eol),
    .i_cost(i_cost),
    .i_dmax(i_dmax),
    .i_thresh_lrcc(i_thresh),
    .i_cost_max(i_cmax),
    .o_ready(o_ready),
    .o_dval(o_dval),
    .o_data(o_data),
    .o_err(o_err),
    .o_eol(o_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DBIT-1:0] data;
    logic            err;
    logic            eol;
    int              x;
  } exp_t;

  exp_t q[$];
  int   cst [64][64];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   eol_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [DBIT+1:0] got;
    logic [DBIT+1:0] want;
    if (!rst && o_dval === 1'b1) begin
      n_cmp++;
      got = {o_data, o_err, o_eol};
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out data=%0d err=%0d eol=%0d",
                 o_data, o_err, o_eol);
      end else begin
        e = q.pop_front();
        want = {e.data, e.err, e.eol};
        if (got !== want) begin
          n_bad++;
          $display("FAIL px%0d data/err/eol got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   e.x, o_data, o_err, o_eol, e.data, e.err, e.eol);
        end
      end
      if (o_eol) eol_cyc = cyc;
    end
  end

  function automatic int mc(int x, int d, int n, int dm);
    if (x >= n || d > dm || d > x) return CMAX;
    return cst[x][d];
  endfunction

  task automatic push_line(int n, int dm, int th, int cm);
    int   dr [64];
    int   best;
    int   bd;
    int   cl;
    int   dlv;
    int   df;
    exp_t e;
    for (int r = 0; r < n; r++) begin
      best = mc(r, 0, n, dm);
      bd   = 0;
      for (int k = 1; k <= dm; k++)
        if (mc(r+k, k, n, dm) < best) begin
          best = mc(r+k, k, n, dm);
          bd   = k;
        end
      dr[r] = bd;
    end
    for (int x = 0; x < n; x++) begin
      cl  = cst[x][0];
      dlv = 0;
      for (int d = 1; d <= dm && d <= x; d++)
        if (cst[x][d] < cl) begin
          cl  = cst[x][d];
          dlv = d;
        end
      df = dlv - dr[x-dlv];
      if (df < 0) df = -df;
      e.err  = (df > th) || (cl > cm);
      e.data = e.err ? '0 : DBIT'(dlv);
      e.eol  = (x == n-1);
      e.x    = x;
      q.push_back(e);
    end
  endtask

  task automatic fill(int n, int mode);
    for (int x = 0; x < n; x++)
      for (int d = 0; d < D; d++)
        case (mode)
          0:       cst[x][d] = (d == 5) ? 10 : 100;
          1:       cst[x][d] = 50;
          2:       cst[x][d] = $urandom_range(0, 31);
          default: cst[x][d] = $urandom_range(0, CMAX);
        endcase
  endtask

  task automatic junk();
    for (int j = 0; j < 24; j++) i_cost[j*32 +: 32] = $urandom;
  endtask

  task automatic put_px(int x, bit eol, int gap);
    while ($urandom_range(0, 99) < gap) begin
      i_dval = 1'b0;
      junk();
      @(posedge clk); #1;
    end
    i_dval = 1'b1;
    i_eol  = eol;
    for (int d = 0; d < D; d++)
      i_cost[d*CBIT +: CBIT] = CBIT'(cst[x][d]);
    @(posedge clk); #1;
    i_dval = 1'b0;
    i_eol  = 1'b0;
  endtask

  task automatic send_line(int n, int dm, int th, int cm, int mode, int gap);
    int fl;
    int last;
    fill(n, mode);
    push_line(n, dm, th, cm);
    i_thresh = DBIT'(th);
    i_cmax   = CBIT'(cm);
    i_dmax   = DBIT'(dm);
    eol_cyc  = -1;
    for (int x = 0; x < n; x++) begin
      put_px(x, x == n-1, gap);
      if (x == 0) i_dmax = DBIT'($urandom);
    end
    fl = 0;
    while (!o_ready && fl < 200) begin
      i_dval = 1'b1;
      i_eol  = 1'b1;
      junk();
      @(posedge clk); #1;
      fl++;
    end
    i_dval = 1'b0;
    i_eol  = 1'b0;
    last   = cyc;
    chk("flush_len", fl, dm);
    repeat (3) begin @(posedge clk); #1; end
    chk("eol_latency", eol_cyc - last, 2);
  endtask

  initial begin : watchdog
    #600000;
    n_bad++;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : driver
    int n;
    int dm;
    rst      = 1'b1;
    i_dval   = 1'b0;
    i_eol    = 1'b0;
    i_cost   = '0;
    i_dmax   = '0;
    i_thresh = '0;
    i_cmax   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dval", int'(o_dval), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_eol", int'(o_eol), 0);
    chk("rst_ready", int'(o_ready), 1);
    rst = 1'b0;

    send_line(40, 15, 1, CMAX, 0, 0);
    send_line(40, 15, 1, CMAX, 1, 0);
    send_line(40, 15, 1, 9, 0, 0);
    send_line(40, 15, 1, CMAX, 0, 30);

    fill(40, 0);
    push_line(40, 15, 1, CMAX);
    i_thresh = 6'd1;
    i_cmax   = 12'(CMAX);
    i_dmax   = 6'd15;
    for (int x = 0; x < 20; x++) put_px(x, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_dval", int'(o_dval), 0);
    chk("post_rst_ready", int'(o_ready), 1);
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", int'(o_dval), 0);
    @(posedge clk); #1;
    send_line(40, 15, 1, CMAX, 0, 0);

    send_line(1, 63, 0, CMAX, 2, 0);
    send_line(12, 0, 0, 20, 2, 0);
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(1, 48);
      case ($urandom_range(0, 3))
        0:       dm = 0;
        1:       dm = 63;
        default: dm = $urandom_range(1, 20);
      endcase
      if (i[0])
        send_line(n, dm, $urandom_range(0, 3), CMAX, 3, 30);
      else
        send_line(n, dm, $urandom_range(0, 3),
                  $urandom_range(0, 40), 2, $urandom_range(0, 1) * 30);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
